serial_subtractor_fsm: RTL and testbench



---
 rtl/subtractor_pkg.sv | 17 +
 rtl/full_subtractor_dataflow.sv | 14 +
 rtl/serial_subtractor_fsm.sv | 121 ++++++++++++
 tb/tb_serial_subtractor_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state codes and their width.
// Imported by the serial subtractor top level.
package subtractor_pkg;

    localparam int ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN  = 2'd1;
    localparam logic [ST_W-1:0] ST_DONE = 2'd2;

    typedef enum logic [ST_W-1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/full_subtractor_dataflow.sv
// One-bit full subtractor cell: diff = x - y - b_in, with borrow out.
// Purely combinational; the serial top level reuses it once per bit.
module full_subtractor_dataflow (
    input  logic x,
    input  logic y,
    input  logic b_in,
    output logic diff,
    output logic b_out
);

    assign diff  = x ^ y ^ b_in;
    assign b_out = (~x & y) | (~(x ^ y) & b_in);

endmodule

// File: rtl/serial_subtractor_fsm.sv
// Bit-serial WIDTH-bit subtractor (diff = x - y - b_in), LSB first through a single cell.
// A start/ready/done handshake launches one operation every WIDTH+2 cycles.
module serial_subtractor_fsm
    import subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_x_sr;
    logic [WIDTH-1:0]   r_y_sr;
    logic [WIDTH-1:0]   r_diff_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_borrow;
    logic               r_ready;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_diff;
    logic               r_b_out;
    logic               r_ovf;

    logic               w_d;
    logic               w_bo;
    logic               w_b_msb;
    logic [WIDTH-1:0]   w_diff_next;

    full_subtractor_dataflow u_cell (
        .x     (r_x_sr[0]),
        .y     (r_y_sr[0]),
        .b_in  (r_borrow),
        .diff  (w_d),
        .b_out (w_bo)
    );

    // On the final bit the borrow register holds the borrow into the MSB.
    assign w_b_msb     = r_borrow;
    assign w_diff_next = {w_d, r_diff_sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_x_sr    <= '0;
            r_y_sr    <= '0;
            r_diff_sr <= '0;
            r_cnt     <= '0;
            r_borrow  <= 1'b0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_diff    <= '0;
            r_b_out   <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x_sr    <= x;
                        r_y_sr    <= y;
                        r_borrow  <= b_in;
                        r_diff_sr <= '0;
                        r_cnt     <= '0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_x_sr    <= r_x_sr >> 1;
                    r_y_sr    <= r_y_sr >> 1;
                    r_diff_sr <= w_diff_next;
                    r_borrow  <= w_bo;
                    if (r_cnt == LAST_BIT) begin
                        r_diff  <= w_diff_next;
                        r_b_out <= w_bo;
                        r_ovf   <= w_b_msb ^ w_bo;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign busy  = r_busy;
    assign done  = r_done;
    assign diff  = r_diff;
    assign b_out = r_b_out;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_subtractor_fsm.sv
// Scoreboard bench for serial_subtractor_fsm: WIDTH=8 directed/random ops and a WIDTH=2 exhaustive sweep.
// Expected results come from a plain-arithmetic reference model and are checked by done-driven monitors.
module tb_serial_subtractor_fsm;

    typedef struct {
        logic [7:0] diff;
        logic       bOut;
        logic       ovf;
        int         acceptCycle;
    } expect_t;

    logic       clk;
    logic       rst;

    logic       start8, bIn8, ready8, busy8, done8, bOut8, ovf8;
    logic [7:0] x8, y8, diff8;

    logic       start2, bIn2, ready2, busy2, done2, bOut2, ovf2;
    logic [1:0] x2, y2, diff2;

    int         cycleCount;
    int         checkCount;
    int         passCount;
    logic       prevDone8;
    logic       prevDone2;
    expect_t    q8[$];
    expect_t    q2[$];

    serial_subtractor_fsm #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .x     (x8),
        .y     (y8),
        .b_in  (bIn8),
        .ready (ready8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .b_out (bOut8),
        .ovf   (ovf8)
    );

    serial_subtractor_fsm #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .x     (x2),
        .y     (y2),
        .b_in  (bIn2),
        .ready (ready2),
        .busy  (busy2),
        .done  (done2),
        .diff  (diff2),
        .b_out (bOut2),
        .ovf   (ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Reference: unsigned and signed interpretations of x - y - b_in in a w-bit field.
    function automatic expect_t refModel(input int w, input int a, input int b, input int bi);
        expect_t e;
        int m, r, sa, sb, sr;
        m  = 1 << w;
        r  = a - b - bi;
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sr = sa - sb - bi;
        e.diff        = 8'((r + m) % m);
        e.bOut        = (r < 0);
        e.ovf         = (sr < -(m / 2)) || (sr > (m / 2) - 1);
        e.acceptCycle = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkResetState();
        checkOutput("rstReady", 32'(ready8), 32'd1);
        checkOutput("rstBusy",  32'(busy8),  32'd0);
        checkOutput("rstDone",  32'(done8),  32'd0);
        checkOutput("rstDiff",  32'(diff8),  32'd0);
        checkOutput("rstBOut",  32'(bOut8),  32'd0);
        checkOutput("rstOvf",   32'(ovf8),   32'd0);
    endtask

    task automatic waitReady(input int w);
        for (int i = 0; i < 60; i++) begin
            if ((w == 8) ? ready8 : ready2) break;
            @(negedge clk);
        end
        if (!((w == 8) ? ready8 : ready2))
            checkOutput("readyTimeout", 32'((w == 8) ? ready8 : ready2), 32'd1);
    endtask

    // Called at a negedge; the following posedge is the accepting edge.
    task automatic applyStimulus(input int w, input int a, input int b, input int bi, input bit track);
        expect_t e;
        waitReady(w);
        if (w == 8) begin
            x8 = 8'(a); y8 = 8'(b); bIn8 = 1'(bi); start8 = 1'b1;
        end else begin
            x2 = 2'(a); y2 = 2'(b); bIn2 = 1'(bi); start2 = 1'b1;
        end
        if (track) begin
            e = refModel(w, a, b, bi);
            e.acceptCycle = cycleCount + 1;
            if (w == 8) q8.push_back(e);
            else        q2.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
        start2 = 1'b0;
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (done8) begin
            checkOutput("done8Width", 32'(prevDone8), 32'd0);
            if (q8.size() == 0) begin
                checkOutput("done8WithoutRequest", 32'(done8), 32'd0);
            end else begin
                e = q8.pop_front();
                checkOutput("diff8",    32'(diff8), 32'(e.diff));
                checkOutput("bOut8",    32'(bOut8), 32'(e.bOut));
                checkOutput("ovf8",     32'(ovf8),  32'(e.ovf));
                checkOutput("latency8", 32'(cycleCount), 32'(e.acceptCycle + 8));
            end
        end
        prevDone8 = done8;
    end

    always @(negedge clk) begin
        expect_t e;
        if (done2) begin
            checkOutput("done2Width", 32'(prevDone2), 32'd0);
            if (q2.size() == 0) begin
                checkOutput("done2WithoutRequest", 32'(done2), 32'd0);
            end else begin
                e = q2.pop_front();
                checkOutput("diff2",    32'(diff2), 32'(e.diff));
                checkOutput("bOut2",    32'(bOut2), 32'(e.bOut));
                checkOutput("ovf2",     32'(ovf2),  32'(e.ovf));
                checkOutput("latency2", 32'(cycleCount), 32'(e.acceptCycle + 2));
            end
        end
        prevDone2 = done2;
    end

    initial begin
        expect_t e;
        int      k;
        int      guard;
        cycleCount = 0;
        checkCount = 0;
        passCount  = 0;
        prevDone8  = 1'b0;
        prevDone2  = 1'b0;
        rst = 1'b1;
        start8 = 1'b0; x8 = '0; y8 = '0; bIn8 = 1'b0;
        start2 = 1'b0; x2 = '0; y2 = '0; bIn2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetState();
        @(negedge clk);

        // Operands are altered during RUN; the captured values must win.
        applyStimulus(8, 100, 37, 0, 1'b1);
        checkOutput("busyAfterAccept",  32'(busy8),  32'd1);
        checkOutput("readyAfterAccept", 32'(ready8), 32'd0);
        x8 = 8'hFF; y8 = 8'hAA; bIn8 = 1'b1;

        applyStimulus(8, 8'h00, 8'h01, 0, 1'b1);
        applyStimulus(8, 8'h05, 8'h05, 1, 1'b1);
        applyStimulus(8, 8'h80, 8'h01, 0, 1'b1);
        applyStimulus(8, 8'h7F, 8'hFF, 0, 1'b1);

        // start pulses during RUN and during DONE must not launch anything.
        applyStimulus(8, 8'h33, 8'h11, 0, 1'b1);
        repeat (2) @(negedge clk);
        start8 = 1'b1; x8 = 8'h00; y8 = 8'h77;
        @(negedge clk);
        start8 = 1'b0;
        guard = 0;
        while (!done8 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("doneSeenForIgnoreTest", 32'(done8), 32'd1);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;

        // start held high: three back-to-back ops spaced WIDTH+2 cycles apart.
        waitReady(8);
        x8 = 8'h42; y8 = 8'h24; bIn8 = 1'b1; start8 = 1'b1;
        k = cycleCount + 1;
        for (int i = 0; i < 3; i++) begin
            e = refModel(8, 8'h42, 8'h24, 1);
            e.acceptCycle = k + 10 * i;
            q8.push_back(e);
        end
        repeat (25) @(negedge clk);
        start8 = 1'b0;

        // Asynchronous reset after three RUN edges aborts with no done pulse.
        applyStimulus(8, 8'hAB, 8'h12, 0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1 checkResetState();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(8, 8'h10, 8'h01, 0, 1'b1);

        for (int i = 0; i < 20; i++)
            applyStimulus(8, int'($urandom_range(255)), int'($urandom_range(255)),
                          int'($urandom_range(1)), 1'b1);

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int bi = 0; bi < 2; bi++)
                    applyStimulus(2, a, b, bi, 1'b1);

        guard = 0;
        while ((q8.size() != 0 || q2.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        checkOutput("queue8Drained", 32'(q8.size()), 32'd0);
        checkOutput("queue2Drained", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
